// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer: pulses the PLL reset, waits for a stable lock, then releases the
// downstream reset. It retries on timeout and re-sequences on loss of lock. Clocked by refclk.
module pll_lock_sequencer #(
  parameter int unsigned RST_CYCLES     = 16,
  parameter int unsigned STABLE_CYCLES  = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 65536,
  parameter int unsigned MAX_RETRIES    = 3,
  parameter int unsigned CNT_W          = 17
) (
  input  logic                               refclk,
  input  logic                               rst,
  input  logic                               pll_locked,
  input  logic                               relock_req,
  output logic                               pll_rst,
  output logic                               reset_out,
  output logic                               ready,
  output logic                               fail,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt,
  output logic [7:0]                         lock_loss_cnt
);

  localparam int unsigned RetryW = $clog2(MAX_RETRIES + 1);
  localparam logic [RetryW-1:0] MaxRetry = RetryW'(MAX_RETRIES);
  localparam logic [CNT_W-1:0] RstLast   = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] StabLast  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ToLast    = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] StPllRst   = 3'd0;
  localparam logic [2:0] StWaitLock = 3'd1;
  localparam logic [2:0] StStable   = 3'd2;
  localparam logic [2:0] StRun      = 3'd3;
  localparam logic [2:0] StFail     = 3'd4;

  logic              sync_q;
  logic              locked_s;
  logic [2:0]        state_q, state_d;
  // cnt_q serves as rst_cnt in PLL_RST and stab_cnt in STABLE; att_q spans the whole attempt.
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  att_q, att_d, att_inc;
  logic [RetryW-1:0] retry_d;
  logic [7:0]        loss_d;
  logic              timeout;

  assign att_inc = (att_q == '1) ? att_q : att_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    att_d   = att_q;
    retry_d = retry_cnt;
    loss_d  = lock_loss_cnt;
    timeout = 1'b0;

    case (state_q)
      StPllRst: begin
        if (relock_req) begin
          cnt_d   = '0;
          retry_d = '0;
        end else if (cnt_q == RstLast) begin
          state_d = StWaitLock;
          cnt_d   = '0;
          att_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWaitLock: begin
        if (relock_req) begin
          state_d = StPllRst;
          cnt_d   = '0;
          retry_d = '0;
        end else if (locked_s) begin
          state_d = StStable;
          cnt_d   = '0;
          att_d   = att_inc;
        end else if (att_q >= ToLast) begin
          timeout = 1'b1;
        end else begin
          att_d = att_inc;
        end
      end
      StStable: begin
        if (relock_req) begin
          state_d = StPllRst;
          cnt_d   = '0;
          retry_d = '0;
        end else if (locked_s && (cnt_q == StabLast)) begin
          state_d = StRun;
          cnt_d   = '0;
        end else if (!locked_s) begin
          // Attempt timer keeps running across a lock glitch; no retry is charged.
          state_d = StWaitLock;
          cnt_d   = '0;
          att_d   = att_inc;
        end else if (att_q >= ToLast) begin
          timeout = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
          att_d = att_inc;
        end
      end
      StRun: begin
        if (!locked_s) begin
          state_d = StPllRst;
          cnt_d   = '0;
          retry_d = '0;
          if (lock_loss_cnt != 8'hFF) loss_d = lock_loss_cnt + 1'b1;
        end else if (relock_req) begin
          state_d = StPllRst;
          cnt_d   = '0;
          retry_d = '0;
        end
      end
      StFail: begin
        if (relock_req) begin
          state_d = StPllRst;
          cnt_d   = '0;
          retry_d = '0;
        end
      end
      default: begin
        state_d = StPllRst;
        cnt_d   = '0;
      end
    endcase

    if (timeout) begin
      if (retry_cnt < MaxRetry) begin
        retry_d = retry_cnt + 1'b1;
        state_d = StPllRst;
        cnt_d   = '0;
      end else begin
        state_d = StFail;
      end
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      sync_q        <= 1'b0;
      locked_s      <= 1'b0;
      state_q       <= StPllRst;
      cnt_q         <= '0;
      att_q         <= '0;
      retry_cnt     <= '0;
      lock_loss_cnt <= '0;
      pll_rst       <= 1'b1;
      reset_out     <= 1'b1;
      ready         <= 1'b0;
      fail          <= 1'b0;
    end else begin
      sync_q        <= pll_locked;
      locked_s      <= sync_q;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      att_q         <= att_d;
      retry_cnt     <= retry_d;
      lock_loss_cnt <= loss_d;
      // Outputs follow the next state so they change on the same edge as the transition.
      pll_rst       <= (state_d == StPllRst) || (state_d == StFail);
      reset_out     <= (state_d != StRun);
      ready         <= (state_d == StRun);
      fail          <= (state_d == StFail);
    end
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboard bench for pll_lock_sequencer: a timestamp-based reference model predicts every
// cycle's outputs, and a separate monitor pops and compares them.
module tb_pll_lock_sequencer;

  localparam int unsigned RstC  = 4;
  localparam int unsigned StabC = 8;
  localparam int unsigned ToC   = 32;
  localparam int unsigned MaxR  = 2;
  localparam int unsigned CntW  = 8;

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       relock_req = 1'b0;
  logic       pll_rst, reset_out, ready, fail;
  logic [1:0] retry_cnt;
  logic [7:0] lock_loss_cnt;

  pll_lock_sequencer #(
    .RST_CYCLES    (RstC),
    .STABLE_CYCLES (StabC),
    .TIMEOUT_CYCLES(ToC),
    .MAX_RETRIES   (MaxR),
    .CNT_W         (CntW)
  ) dut (
    .refclk       (refclk),
    .rst          (rst),
    .pll_locked   (pll_locked),
    .relock_req   (relock_req),
    .pll_rst      (pll_rst),
    .reset_out    (reset_out),
    .ready        (ready),
    .fail         (fail),
    .retry_cnt    (retry_cnt),
    .lock_loss_cnt(lock_loss_cnt)
  );

  always #5 refclk = ~refclk;

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void check(string name, int act, int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endfunction

  // Reference model: phases tracked by the edge at which they started.
  typedef enum int {MReset, MWait, MStable, MRun, MFail} mmode_e;
  mmode_e m_mode = MReset;
  int     m_now = 0;
  int     m_phase_t0 = 0;
  int     m_att_t0 = 0;
  int     m_retries = 0;
  int     m_losses = 0;
  bit     m_hist[$];

  function automatic void m_enter_reset();
    m_mode     = MReset;
    m_phase_t0 = m_now + 1;
  endfunction

  function automatic void m_step(logic r, logic lk, logic rq);
    bit ls;
    bit to;
    to = 1'b0;
    if (r) begin
      m_hist    = {1'b0, 1'b0};
      m_retries = 0;
      m_losses  = 0;
      m_enter_reset();
    end else begin
      ls = m_hist.pop_front();
      m_hist.push_back(lk);
      case (m_mode)
        MReset: begin
          if (rq) begin
            m_retries = 0;
            m_enter_reset();
          end else if (m_now - m_phase_t0 == int'(RstC) - 1) begin
            m_mode   = MWait;
            m_att_t0 = m_now + 1;
          end
        end
        MWait: begin
          if (rq) begin
            m_retries = 0;
            m_enter_reset();
          end else if (ls) begin
            m_mode     = MStable;
            m_phase_t0 = m_now + 1;
          end else if (m_now - m_att_t0 >= int'(ToC) - 1) begin
            to = 1'b1;
          end
        end
        MStable: begin
          if (rq) begin
            m_retries = 0;
            m_enter_reset();
          end else if (ls && (m_now - m_phase_t0 == int'(StabC) - 1)) begin
            m_mode = MRun;
          end else if (!ls) begin
            m_mode = MWait;
          end else if (m_now - m_att_t0 >= int'(ToC) - 1) begin
            to = 1'b1;
          end
        end
        MRun: begin
          if (!ls) begin
            if (m_losses < 255) m_losses++;
            m_retries = 0;
            m_enter_reset();
          end else if (rq) begin
            m_retries = 0;
            m_enter_reset();
          end
        end
        MFail: begin
          if (rq) begin
            m_retries = 0;
            m_enter_reset();
          end
        end
        default: m_enter_reset();
      endcase
      if (to) begin
        if (m_retries < int'(MaxR)) begin
          m_retries++;
          m_enter_reset();
        end else begin
          m_mode = MFail;
        end
      end
    end
    m_now++;
  endfunction

  function automatic logic [13:0] m_expected();
    logic [1:0] rc;
    logic [7:0] lc;
    rc = m_retries[1:0];
    lc = m_losses[7:0];
    return {(m_mode == MReset) || (m_mode == MFail), m_mode != MRun, m_mode == MRun,
            m_mode == MFail, rc, lc};
  endfunction

  logic [13:0] exp_q[$];

  task automatic tick(input logic r, input logic lk, input logic rq);
    @(negedge refclk);
    rst        = r;
    pll_locked = lk;
    relock_req = rq;
    m_step(r, lk, rq);
    exp_q.push_back(m_expected());
  endtask

  task automatic flush();
    @(posedge refclk);
    #2;
  endtask

  // Monitor: compares every cycle and records a few event times for the directed checks.
  logic [13:0] exp_v;
  int          mon_cyc = 0;
  int          edge_no = -1;
  int          ready_rise = -1;
  int          fail_rise = -1;
  int          relock_edge = -1;
  logic        prev_ready = 1'b0;
  logic        prev_fail = 1'b0;
  logic [7:0]  last_loss = 8'h0;

  always @(posedge refclk) begin
    #1;
    if (exp_q.size() != 0) begin
      exp_v = exp_q.pop_front();
      check($sformatf("outputs cycle %0d", mon_cyc),
            int'({pll_rst, reset_out, ready, fail, retry_cnt, lock_loss_cnt}), int'(exp_v));
    end
    mon_cyc++;
    if (rst) begin
      edge_no    = -1;
      ready_rise = -1;
      fail_rise  = -1;
    end else begin
      edge_no++;
      if (relock_req) relock_edge = edge_no;
      if (ready && !prev_ready) ready_rise = edge_no;
      if (fail && !prev_fail) fail_rise = edge_no;
    end
    prev_ready = ready;
    prev_fail  = fail;
    last_loss  = lock_loss_cnt;
  end

  initial begin
    int  seg;
    logic lk;

    // Lock tied high: ready first seen at cycle 13.
    repeat (3) tick(1'b1, 1'b1, 1'b0);
    repeat (20) tick(1'b0, 1'b1, 1'b0);
    flush();
    check("t1 ready rise edge", ready_rise, 12);

    // One-cycle lock glitch mid-STABLE.
    repeat (2) tick(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 30; i++) tick(1'b0, (i != 9), 1'b0);
    flush();
    check("t2 ready rise edge", ready_rise, 20);

    // Lock tied low: two retries, then FAIL at cycle 108.
    repeat (2) tick(1'b1, 1'b0, 1'b0);
    repeat (115) tick(1'b0, 1'b0, 1'b0);
    flush();
    check("t3 fail rise edge", fail_rise, 107);

    // Relock from FAIL.
    repeat (3) tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b1);
    repeat (20) tick(1'b0, 1'b1, 1'b0);
    flush();
    check("t5 relock to ready", ready_rise - relock_edge, 13);

    // 300 lock losses in RUN saturate the loss counter.
    for (int n = 0; n < 300; n++) begin
      tick(1'b0, 1'b0, 1'b0);
      repeat (18) tick(1'b0, 1'b1, 1'b0);
    end
    flush();
    check("t4 loss saturation", int'(last_loss), 255);

    // rst mid-STABLE restarts the sequence.
    repeat (2) tick(1'b1, 1'b1, 1'b0);
    repeat (8) tick(1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    repeat (20) tick(1'b0, 1'b1, 1'b0);
    flush();
    check("t6a ready rise edge", ready_rise, 12);

    // rst in RUN with three losses clears the loss counter.
    for (int n = 0; n < 3; n++) begin
      tick(1'b0, 1'b0, 1'b0);
      repeat (18) tick(1'b0, 1'b1, 1'b0);
    end
    flush();
    check("t6b losses before rst", int'(last_loss), 3);
    tick(1'b1, 1'b1, 1'b0);
    flush();
    check("t6b losses after rst", int'(last_loss), 0);
    repeat (20) tick(1'b0, 1'b1, 1'b0);
    flush();
    check("t6b ready rise edge", ready_rise, 12);

    // Random lock waveforms with occasional relock requests and resets.
    seg = 0;
    lk  = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (seg == 0) begin
        lk  = ($urandom_range(0, 3) != 0);
        seg = lk ? int'($urandom_range(1, 60)) : int'($urandom_range(1, 45));
      end
      seg--;
      tick(($urandom_range(0, 599) == 0), lk, ($urandom_range(0, 149) == 0));
    end
    repeat (2) tick(1'b0, 1'b1, 1'b0);
    flush();
    flush();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
- Controls the reset and lock sequence of the system/SDRAM PLL and generates the downstream reset from it.
- Pulses the PLL reset and waits for the PLL locked signal.
- Requires lock to stay stable for a set time before releasing the downstream reset to the SDRAM controller and fabric.
- Retries a bounded number of times on lock timeout and re-sequences on loss of lock.
- Runs on the free-running PLL reference clock, never on a PLL output.

Parameters:
- RST_CYCLES, 16: cycles pll_rst is held high per attempt; must be ≥1.
- STABLE_CYCLES, 1024: consecutive synchronized-lock cycles required before release.
- TIMEOUT_CYCLES, 65536: per-attempt limit from entry into WAIT_LOCK to reaching RUN.
- MAX_RETRIES, 3: re-attempts after the first timeout before entering FAIL.
- CNT_W, 17: shared counter width; must hold max(RST_CYCLES, STABLE_CYCLES, TIMEOUT_CYCLES).

Ports:
- refclk, input, 1: sole clock, the PLL reference clock.
- rst, input, 1: synchronous, active-high reset.
- pll_locked, input, 1: PLL lock indication, asynchronous to refclk.
- relock_req, input, 1: single-cycle pulse that forces a new lock sequence.
- pll_rst, output, 1: reset to the PLL.
- reset_out, output, 1: active-high reset to the downstream logic.
- ready, output, 1: PLL locked and stable, downstream out of reset.
- fail, output, 1: retries exhausted.
- retry_cnt, output, $clog2(MAX_RETRIES+1): number of timeouts in the current sequence.
- lock_loss_cnt, output, 8: saturating count of lock losses seen in RUN.

Behaviour:
- Synchronizer: locked_s is a 2-flop synchronizer of pll_locked. All decisions use locked_s (2-cycle input latency). Both flops clear under rst.
- Outputs are registered and update on the same edge as the state transition.
- States: PLL_RST, WAIT_LOCK, STABLE, RUN, FAIL.
- Under rst: state=PLL_RST, counters=0, pll_rst=1, reset_out=1, ready=0, fail=0, retry_cnt=0, lock_loss_cnt=0.
- rst asserted in any state returns to these values on the next edge. lock_loss_cnt is cleared only by rst.
- PLL_RST:
  - pll_rst=1, reset_out=1; rst_cnt increments.
  - At rst_cnt==RST_CYCLES-1, go to WAIT_LOCK and clear att_cnt.
  - pll_rst is therefore high for exactly RST_CYCLES cycles after rst falls.
- WAIT_LOCK:
  - pll_rst=0; att_cnt increments every cycle.
  - If locked_s=1, go to STABLE with stab_cnt=0.
  - Otherwise, at att_cnt==TIMEOUT_CYCLES-1, take the timeout action.
  - If lock and timeout occur in the same cycle, lock wins.
- STABLE:
  - att_cnt keeps running; stab_cnt increments while locked_s=1.
  - If locked_s=0, go back to WAIT_LOCK. stab_cnt clears, att_cnt is not cleared, and there is no retry increment.
  - At stab_cnt==STABLE_CYCLES-1 with locked_s=1, go to RUN. This takes precedence over timeout.
- Timeout action:
  - If retry_cnt<MAX_RETRIES: retry_cnt++, go to PLL_RST, rst_cnt=0.
  - Otherwise go to FAIL.
- RUN:
  - reset_out=0, ready=1.
  - If locked_s=0: lock_loss_cnt++ (saturates at 255), retry_cnt=0, go to PLL_RST. reset_out=1 and ready=0 take effect on the same edge.
  - Worst case from pll_locked falling to reset_out rising is 3 edges.
  - relock_req in RUN goes to PLL_RST with retry_cnt=0 and no loss count. If relock_req and lock loss occur in the same cycle, the loss is counted.
- FAIL:
  - fail=1, pll_rst=1 (PLL held in reset), reset_out=1, ready=0; retry_cnt holds its value.
  - Exits only on rst, or on relock_req to PLL_RST with fail=0 and retry_cnt=0.
- relock_req in PLL_RST, WAIT_LOCK or STABLE restarts at PLL_RST with rst_cnt=0 and retry_cnt=0.
- ready and reset_out are always complementary, except that both are 0 never; ready=1 implies reset_out=0.

Test Plan:
All tests use RST_CYCLES=4, STABLE_CYCLES=8, TIMEOUT_CYCLES=32, MAX_RETRIES=2. Cycle 0 is the first edge with rst=0.
1. pll_locked tied 1 → pll_rst=1 for cycles 0-3; WAIT_LOCK at 4; STABLE for 5-12; ready=1 and reset_out=0 from cycle 13; retry_cnt=0.
2. pll_locked=1, then low for 1 cycle at cycle 9 (mid-STABLE) → returns to WAIT_LOCK, then STABLE again; ready rises 8+ cycles after lock recovers; retry_cnt stays 0.
3. pll_locked tied 0 → pll_rst pulses at cycles 0-3, 36-39 and 72-75; retry_cnt becomes 1 at 36 and 2 at 72; FAIL at 108 with fail=1, pll_rst=1, reset_out=1.
4. In RUN, pll_locked falls → reset_out=1 and ready=0 within 3 edges; pll_rst=1 for 4 cycles; lock_loss_cnt=1. Repeat 300 times → lock_loss_cnt=255.
5. From FAIL, relock_req pulse with pll_locked=1 → fail=0 on the next edge; ready=1 exactly 13 cycles after the relock_req edge.
6. rst asserted for 1 cycle mid-STABLE, or in RUN with lock_loss_cnt=3 → next edge: pll_rst=1, reset_out=1, ready=0, lock_loss_cnt=0; the sequence then restarts as in test 1.
